// File: rtl/mmult_seq.sv
// Matrix element address walker: steps through N longword addresses by row
// (stride 1) or by column (stride N) with valid/ready handshake and done pulse.
module mmult_seq (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       start,
    input  logic [9:0] base,
    input  logic [3:0] mwidth,
    input  logic       maddw,
    input  logic       out_ready,
    output logic [9:0] maddr,
    output logic       out_valid,
    output logic [3:0] idx,
    output logic       last,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state;
    logic [3:0] n_m1;
    logic       col;
    logic [9:0] stride;

    // N-1 wraps naturally: mwidth=0 gives 15, i.e. N=16.
    always_comb begin
        stride    = col ? ({6'b0, n_m1} + 10'd1) : 10'd1;
        out_valid = (state == S_RUN);
        last      = out_valid && (idx == n_m1);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= S_IDLE;
            maddr <= '0;
            idx   <= '0;
            n_m1  <= '0;
            col   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        maddr <= base;
                        idx   <= '0;
                        n_m1  <= mwidth - 4'd1;
                        col   <= maddw;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (out_ready) begin
                        if (last) begin
                            state <= S_DONE;
                        end else begin
                            maddr <= maddr + stride;
                            idx   <= idx + 4'd1;
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
